// File: rtl/secuenciador_pila_if.sv
// Bus between the control unit / program memory and the sequencer.
//   master : control side, drives the sequencing request (enable, op,
//            target, zero, resume) and observes pc and status.
//   slave  : sequencer side, consumes the request and drives pc, sp
//            and the status decodes.
// SP_W is derived from STACK_DEPTH and must not be overridden.
interface secuenciador_pila_if #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic            enable;
    logic [2:0]      op;
    logic [PC_W-1:0] target;
    logic            zero;
    logic            resume;

    logic [PC_W-1:0] pc;
    logic [SP_W-1:0] sp;
    logic            stack_full;
    logic            stack_empty;
    logic            halted;
    logic            error;

    modport master (
        output enable, op, target, zero, resume,
        input  pc, sp, stack_full, stack_empty, halted, error
    );

    modport slave (
        input  enable, op, target, zero, resume,
        output pc, sp, stack_full, stack_empty, halted, error
    );
endinterface

// File: rtl/secuenciador_pila.sv
// Program-counter sequencer with a return-address stack.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : asynchronous active-low reset (0 = in reset)
//   bus    : slave side of secuenciador_pila_if
//            in : enable, op, target, zero, resume
//            out: pc, sp, stack_full, stack_empty, halted, error
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_RUN   | executing one sequencing op per enabled cycle
// ST_HALT  | pc/sp frozen, waits for resume with enable
// ST_ERROR | stack overflow/underflow seen, frozen until reset
module secuenciador_pila #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    secuenciador_pila_if.slave  bus
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_JNZ  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt, pc_inc, top_val;
    logic [SP_W-1:0] sp_q, sp_nxt;
    logic            push;
    logic            is_full, is_empty;
    logic [PC_W-1:0] stack_mem [STACK_DEPTH];

    assign pc_inc   = pc_q + PC_W'(1);
    assign is_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign is_empty = (sp_q == '0);

    // Entry at sp-1 is the return address; scanning avoids an index whose
    // width differs from the array depth.
    always_comb begin
        top_val = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                top_val = stack_mem[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        sp_nxt    = sp_q;
        push      = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.enable) begin
                    case (bus.op)
                        OP_JMP:  pc_nxt = bus.target;
                        OP_JZ:   pc_nxt = bus.zero ? bus.target : pc_inc;
                        OP_JNZ:  pc_nxt = bus.zero ? pc_inc : bus.target;
                        OP_CALL: begin
                            if (is_full) begin
                                state_nxt = ST_ERROR;
                            end else begin
                                push   = 1'b1;
                                sp_nxt = sp_q + SP_W'(1);
                                pc_nxt = bus.target;
                            end
                        end
                        OP_RET: begin
                            if (is_empty) begin
                                state_nxt = ST_ERROR;
                            end else begin
                                pc_nxt = top_val;
                                sp_nxt = sp_q - SP_W'(1);
                            end
                        end
                        OP_HALT: state_nxt = ST_HALT;
                        default: pc_nxt = pc_inc;
                    endcase
                end
            end
            ST_HALT: begin
                if (bus.enable && bus.resume) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = pc_inc;
                end
            end
            default: begin
                state_nxt = ST_ERROR;
            end
        endcase
    end

    // Datapath registers; the stack is cleared so no stale return address
    // survives a reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
            sp_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else begin
            pc_q <= pc_nxt;
            sp_q <= sp_nxt;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (push && (sp_q == SP_W'(i))) begin
                    stack_mem[i] <= pc_inc;
                end
            end
        end
    end

    // Outputs: decodes of registered state only
    always_comb begin
        bus.pc          = pc_q;
        bus.sp          = sp_q;
        bus.stack_full  = is_full;
        bus.stack_empty = is_empty;
        bus.halted      = (state == ST_HALT);
        bus.error       = (state == ST_ERROR);
    end
endmodule

// File: tb/tb_secuenciador_pila.sv
module tb_secuenciador_pila;
    localparam int PC_W        = 10;
    localparam int STACK_DEPTH = 4;

    localparam logic [2:0] NEXT = 3'b000;
    localparam logic [2:0] JMP  = 3'b001;
    localparam logic [2:0] JZ   = 3'b010;
    localparam logic [2:0] JNZ  = 3'b011;
    localparam logic [2:0] CALL = 3'b100;
    localparam logic [2:0] RET  = 3'b101;
    localparam logic [2:0] HALT = 3'b110;
    localparam logic [2:0] NXT7 = 3'b111;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    secuenciador_pila_if #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

    secuenciador_pila #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one op and sample 1 time unit after the edge that takes it.
    task automatic do_op(input logic [2:0] o, input logic [PC_W-1:0] t, input logic z);
        bus.op     = o;
        bus.target = t;
        bus.zero   = z;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_async_pc", 32'(bus.pc), 0);
        #1 reset = 1'b1;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset      = 1'b0;
        bus.enable = 1'b1;
        bus.op     = NEXT;
        bus.target = '0;
        bus.zero   = 1'b0;
        bus.resume = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",     32'(bus.pc), 0);
        chk("rst_sp",     32'(bus.sp), 0);
        chk("rst_empty",  32'(bus.stack_empty), 1);
        chk("rst_full",   32'(bus.stack_full), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_error",  32'(bus.error), 0);
        reset = 1'b1;

        // Sequential counting then mid-cycle reset
        for (int i = 1; i <= 5; i++) begin
            do_op(NEXT, '0, 1'b0);
            chk($sformatf("next_pc%0d", i), 32'(bus.pc), 32'(i));
        end
        chk("next_sp",    32'(bus.sp), 0);
        chk("next_empty", 32'(bus.stack_empty), 1);
        pulse_reset();

        // Branches
        repeat (3) do_op(NEXT, '0, 1'b0);
        chk("br_pc3", 32'(bus.pc), 3);
        do_op(JZ, 10'h100, 1'b1);
        chk("jz_taken", 32'(bus.pc), 32'h100);
        do_op(JNZ, 10'h200, 1'b1);
        chk("jnz_not_taken", 32'(bus.pc), 32'h101);
        do_op(JZ, 10'h050, 1'b0);
        chk("jz_not_taken", 32'(bus.pc), 32'h102);
        do_op(JNZ, 10'h060, 1'b0);
        chk("jnz_taken", 32'(bus.pc), 32'h060);
        do_op(JMP, 10'h3FF, 1'b0);
        chk("jmp", 32'(bus.pc), 32'h3FF);
        do_op(NEXT, '0, 1'b0);
        chk("wrap", 32'(bus.pc), 0);
        do_op(NXT7, 10'h123, 1'b1);
        chk("op111_next", 32'(bus.pc), 1);

        // Nested calls
        do_op(JMP, 10'd10, 1'b0);
        do_op(CALL, 10'd20, 1'b0);
        chk("call1_pc", 32'(bus.pc), 20);
        chk("call1_sp", 32'(bus.sp), 1);
        do_op(CALL, 10'd30, 1'b0);
        do_op(CALL, 10'd40, 1'b0);
        do_op(CALL, 10'd50, 1'b0);
        chk("call4_pc",   32'(bus.pc), 50);
        chk("call4_sp",   32'(bus.sp), 4);
        chk("call4_full", 32'(bus.stack_full), 1);
        do_op(RET, '0, 1'b0);
        chk("ret1_pc", 32'(bus.pc), 41);
        chk("ret1_sp", 32'(bus.sp), 3);
        do_op(RET, '0, 1'b0);
        chk("ret2_pc", 32'(bus.pc), 31);
        do_op(RET, '0, 1'b0);
        chk("ret3_pc", 32'(bus.pc), 21);
        do_op(RET, '0, 1'b0);
        chk("ret4_pc",    32'(bus.pc), 11);
        chk("ret4_sp",    32'(bus.sp), 0);
        chk("ret4_empty", 32'(bus.stack_empty), 1);

        // Overflow into sticky error
        do_op(CALL, 10'h100, 1'b0);
        do_op(CALL, 10'h100, 1'b0);
        do_op(CALL, 10'h100, 1'b0);
        do_op(CALL, 10'h103, 1'b0);
        chk("ovf_pre_sp", 32'(bus.sp), 4);
        do_op(CALL, 10'h055, 1'b0);
        chk("ovf_error", 32'(bus.error), 1);
        chk("ovf_pc",    32'(bus.pc), 32'h103);
        chk("ovf_sp",    32'(bus.sp), 4);
        repeat (3) do_op(NEXT, '0, 1'b0);
        bus.resume = 1'b1;
        do_op(RET, '0, 1'b0);
        bus.resume = 1'b0;
        chk("err_sticky", 32'(bus.error), 1);
        chk("err_pc",     32'(bus.pc), 32'h103);
        chk("err_sp",     32'(bus.sp), 4);
        pulse_reset();
        chk("err_cleared", 32'(bus.error), 0);
        chk("err_rst_sp",  32'(bus.sp), 0);

        // Underflow
        do_op(RET, '0, 1'b0);
        chk("udf_error", 32'(bus.error), 1);
        chk("udf_pc",    32'(bus.pc), 0);
        chk("udf_sp",    32'(bus.sp), 0);
        pulse_reset();

        // Halt, resume, stall
        do_op(JMP, 10'd7, 1'b0);
        do_op(HALT, '0, 1'b0);
        chk("halt_flag", 32'(bus.halted), 1);
        chk("halt_pc",   32'(bus.pc), 7);
        repeat (4) do_op(NEXT, '0, 1'b0);
        chk("halt_hold_pc",   32'(bus.pc), 7);
        chk("halt_hold_flag", 32'(bus.halted), 1);
        bus.enable = 1'b0;
        bus.resume = 1'b1;
        do_op(NEXT, '0, 1'b0);
        chk("resume_stalled", 32'(bus.halted), 1);
        chk("resume_stall_pc", 32'(bus.pc), 7);
        bus.enable = 1'b1;
        do_op(NEXT, '0, 1'b0);
        chk("resume_halted", 32'(bus.halted), 0);
        chk("resume_pc",     32'(bus.pc), 8);
        do_op(NEXT, '0, 1'b0);
        chk("resume_in_run", 32'(bus.pc), 9);
        bus.resume = 1'b0;
        bus.enable = 1'b0;
        do_op(JMP, 10'h020, 1'b0);
        chk("stall_jmp", 32'(bus.pc), 9);
        do_op(CALL, 10'h030, 1'b0);
        chk("stall_call_sp", 32'(bus.sp), 0);
        bus.enable = 1'b1;
        do_op(JMP, 10'h020, 1'b0);
        chk("unstall_jmp", 32'(bus.pc), 32'h020);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
